// File: rtl/byte_ser_pkg.sv
// byte_ser_pkg: shared state encoding and lane-count helper for byte_serializer
package byte_ser_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic int lane_count(input int width);
    return width / 8;
  endfunction
endpackage

// File: rtl/byte_serializer.sv
// byte_serializer: emits a DATA_WIDTH word as bytes, valid/ready on both sides, 1 byte/cycle
module byte_serializer
  import byte_ser_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            word_valid,
  input  logic [DATA_WIDTH-1:0]           word_in,
  output logic                            word_ready,
  output logic                            byte_valid,
  output logic [7:0]                      byte_out,
  output logic [$clog2(DATA_WIDTH/8)-1:0] byte_sel,
  output logic                            byte_last,
  input  logic                            byte_ready,
  output logic                            busy
);
  localparam int N = lane_count(DATA_WIDTH);
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST_CNT = SW'(N - 1);
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 16) begin : g_bad_width
    $fatal(1, "byte_serializer: DATA_WIDTH must be a multiple of 8 and at least 16");
  end
  state_t                r_state, w_next;
  logic [SW-1:0]         r_cnt, w_lane;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_word_hs, w_byte_hs;
  // r_cnt counts bytes sent within the word; lane order is applied only at the output
  assign w_lane    = MSB_FIRST ? LAST_CNT - r_cnt : r_cnt;
  assign w_word_hs = word_valid && word_ready;
  assign w_byte_hs = byte_valid && byte_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = flush ? IDLE :
             r_state == IDLE ? (w_word_hs ? SEND : IDLE) :
             (w_byte_hs && byte_last && !w_word_hs) ? IDLE : SEND;
  end
  always_comb begin
    busy       = r_state == SEND;
    byte_valid = busy;
    byte_last  = busy && r_cnt == LAST_CNT;
    byte_sel   = busy ? w_lane : '0;
    byte_out   = busy ? 8'(r_data >> {w_lane, 3'b000}) : 8'h00;
    word_ready = rst_n && !flush && (!busy || (byte_last && byte_ready));
  end
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (w_word_hs) begin
      r_data <= word_in;
      r_cnt  <= '0;
    end else if (w_byte_hs) begin
      r_cnt  <= byte_last ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: directed vector table plus a stall-at-last-byte sequence, both lane orders
module tb_byte_serializer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, flush = 1'b0, word_valid = 1'b0, byte_ready = 1'b1;
  logic [31:0] word_in = '0;
  logic        wr0, bv0, last0, busy0, wr1, bv1, last1, busy1;
  logic [7:0]  b0, b1;
  logic [1:0]  s0, s1;
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  byte_serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .word_valid(word_valid), .word_in(word_in),
    .word_ready(wr0), .byte_valid(bv0), .byte_out(b0), .byte_sel(s0), .byte_last(last0),
    .byte_ready(byte_ready), .busy(busy0));
  byte_serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .word_valid(word_valid), .word_in(word_in),
    .word_ready(wr1), .byte_valid(bv1), .byte_out(b1), .byte_sel(s1), .byte_last(last1),
    .byte_ready(byte_ready), .busy(busy1));
  typedef struct {
    logic rn, fl, wv; logic [31:0] wi; logic br;
    logic wr, bv; logic [7:0] e_b0; logic [1:0] e_s0; logic [7:0] e_b1; logic [1:0] e_s1; logic lst;
  } vec_t;
  vec_t v[40];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic drive(input logic rn, input logic fl, input logic wv, input logic [31:0] wi, input logic br);
    @(negedge clk);
    rst_n = rn; flush = fl; word_valid = wv; word_in = wi; byte_ready = br;
    #1;
  endtask
  initial begin
    //        rn  fl  wv  word_in       br  wr  bv  b0     s0 b1     s1 lst
    v[0]  = '{0, 0, 0, 32'h0,        1, 0, 0, 8'h00, 0, 8'h00, 0, 0};
    v[1]  = '{1, 0, 0, 32'h0,        1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    v[2]  = '{1, 0, 1, 32'h44332211, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    v[3]  = '{1, 0, 0, 32'h0,        1, 0, 1, 8'h11, 0, 8'h44, 3, 0};
    v[4]  = '{1, 0, 0, 32'h0,        1, 0, 1, 8'h22, 1, 8'h33, 2, 0};
    v[5]  = '{1, 0, 0, 32'h0,        1, 0, 1, 8'h33, 2, 8'h22, 1, 0};
    v[6]  = '{1, 0, 0, 32'h0,        1, 1, 1, 8'h44, 3, 8'h11, 0, 1};
    v[7]  = '{1, 0, 0, 32'h0,        1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    v[8]  = '{1, 0, 1, 32'hA0A1A2A3, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    v[9]  = '{1, 0, 1, 32'hB0B1B2B3, 1, 0, 1, 8'hA3, 0, 8'hA0, 3, 0};
    v[10] = '{1, 0, 1, 32'hB0B1B2B3, 1, 0, 1, 8'hA2, 1, 8'hA1, 2, 0};
    v[11] = '{1, 0, 1, 32'hB0B1B2B3, 1, 0, 1, 8'hA1, 2, 8'hA2, 1, 0};
    v[12] = '{1, 0, 1, 32'hB0B1B2B3, 1, 1, 1, 8'hA0, 3, 8'hA3, 0, 1};
    v[13] = '{1, 0, 0, 32'h0,        1, 0, 1, 8'hB3, 0, 8'hB0, 3, 0};
    v[14] = '{1, 0, 0, 32'h0,        1, 0, 1, 8'hB2, 1, 8'hB1, 2, 0};
    v[15] = '{1, 0, 0, 32'h0,        1, 0, 1, 8'hB1, 2, 8'hB2, 1, 0};
    v[16] = '{1, 0, 0, 32'h0,        1, 1, 1, 8'hB0, 3, 8'hB3, 0, 1};
    v[17] = '{1, 0, 0, 32'h0,        1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    v[18] = '{1, 0, 1, 32'h0D0C0B0A, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    v[19] = '{1, 0, 0, 32'hFFFFFFFF, 1, 0, 1, 8'h0A, 0, 8'h0D, 3, 0};
    v[20] = '{1, 0, 0, 32'hFFFFFFFF, 0, 0, 1, 8'h0B, 1, 8'h0C, 2, 0};
    v[21] = '{1, 0, 0, 32'h12345678, 0, 0, 1, 8'h0B, 1, 8'h0C, 2, 0};
    v[22] = '{1, 0, 0, 32'h0,        0, 0, 1, 8'h0B, 1, 8'h0C, 2, 0};
    v[23] = '{1, 0, 0, 32'h0,        1, 0, 1, 8'h0B, 1, 8'h0C, 2, 0};
    v[24] = '{1, 0, 0, 32'h0,        1, 0, 1, 8'h0C, 2, 8'h0B, 1, 0};
    v[25] = '{1, 0, 0, 32'h0,        1, 1, 1, 8'h0D, 3, 8'h0A, 0, 1};
    v[26] = '{1, 0, 0, 32'h0,        1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    v[27] = '{1, 0, 1, 32'h87654321, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    v[28] = '{1, 0, 0, 32'h0,        1, 0, 1, 8'h21, 0, 8'h87, 3, 0};
    v[29] = '{1, 0, 0, 32'h0,        1, 0, 1, 8'h43, 1, 8'h65, 2, 0};
    v[30] = '{1, 1, 1, 32'h55555555, 1, 0, 1, 8'h65, 2, 8'h43, 1, 0};
    v[31] = '{1, 0, 0, 32'h0,        1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    v[32] = '{1, 0, 1, 32'hCAFEBABE, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    v[33] = '{1, 0, 0, 32'h0,        1, 0, 1, 8'hBE, 0, 8'hCA, 3, 0};
    v[34] = '{1, 0, 0, 32'h0,        1, 0, 1, 8'hBA, 1, 8'hFE, 2, 0};
    v[35] = '{0, 0, 0, 32'h0,        1, 0, 1, 8'hFE, 2, 8'hBA, 1, 0};
    v[36] = '{1, 0, 0, 32'h0,        1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    v[37] = '{1, 0, 0, 32'h0,        1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    v[38] = '{1, 0, 1, 32'h01020304, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    v[39] = '{1, 0, 0, 32'h0,        1, 0, 1, 8'h04, 0, 8'h01, 3, 0};
    for (int i = 0; i < 40; i++) begin
      drive(v[i].rn, v[i].fl, v[i].wv, v[i].wi, v[i].br);
      chk($sformatf("v%0d word_ready_lsb", i), 32'(wr0), 32'(v[i].wr));
      chk($sformatf("v%0d word_ready_msb", i), 32'(wr1), 32'(v[i].wr));
      chk($sformatf("v%0d byte_valid_lsb", i), 32'(bv0), 32'(v[i].bv));
      chk($sformatf("v%0d byte_valid_msb", i), 32'(bv1), 32'(v[i].bv));
      chk($sformatf("v%0d busy_lsb", i), 32'(busy0), 32'(v[i].bv));
      chk($sformatf("v%0d busy_msb", i), 32'(busy1), 32'(v[i].bv));
      chk($sformatf("v%0d byte_out_lsb", i), 32'(b0), 32'(v[i].e_b0));
      chk($sformatf("v%0d byte_sel_lsb", i), 32'(s0), 32'(v[i].e_s0));
      chk($sformatf("v%0d byte_out_msb", i), 32'(b1), 32'(v[i].e_b1));
      chk($sformatf("v%0d byte_sel_msb", i), 32'(s1), 32'(v[i].e_s1));
      chk($sformatf("v%0d byte_last_lsb", i), 32'(last0), 32'(v[i].lst));
      chk($sformatf("v%0d byte_last_msb", i), 32'(last1), 32'(v[i].lst));
    end
    // last byte stalled while a new word waits: no acceptance until byte_ready rises
    drive(1, 0, 0, 32'h0, 1);
    chk("h1 byte_out_lsb", 32'(b0), 32'h03);
    drive(1, 0, 0, 32'h0, 1);
    chk("h2 byte_out_lsb", 32'(b0), 32'h02);
    drive(1, 0, 1, 32'h99887766, 0);
    chk("h3 byte_out_lsb", 32'(b0), 32'h01);
    chk("h3 byte_last_lsb", 32'(last0), 32'h1);
    chk("h3 word_ready_stalled", 32'(wr0), 32'h0);
    drive(1, 0, 1, 32'h99887766, 0);
    chk("h4 byte_out_held", 32'(b0), 32'h01);
    chk("h4 word_ready_stalled", 32'(wr1), 32'h0);
    drive(1, 0, 1, 32'h99887766, 1);
    chk("h5 byte_out_lsb", 32'(b0), 32'h01);
    chk("h5 word_ready_lsb", 32'(wr0), 32'h1);
    drive(1, 0, 0, 32'h0, 1);
    chk("h6 byte_valid_lsb", 32'(bv0), 32'h1);
    chk("h6 byte_out_lsb", 32'(b0), 32'h66);
    chk("h6 byte_out_msb", 32'(b1), 32'h99);
    chk("h6 byte_sel_msb", 32'(s1), 32'h3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
